// File: rtl/output_interface.sv
// Round-robin merge of three FWFT issue queues into the c2b packet interface.
// A 2-entry registered buffer decouples the queue pop strobes from b2c_pkt_rdy.
module output_interface #(
  parameter int info_length = 20,
  parameter int order_id    = 3,
  parameter int data_length = 512,
  localparam int buffer_width = 1 + info_length + order_id + 1 + data_length
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [buffer_width-1:0] src1_data,
  input  logic [buffer_width-1:0] src2_data,
  input  logic [buffer_width-1:0] src3_data,
  input  logic                    src1_empty,
  input  logic                    src2_empty,
  input  logic                    src3_empty,
  output logic                    src1_rd,
  output logic                    src2_rd,
  output logic                    src3_rd,
  output logic                    c2b_pkt_vld,
  output logic                    c2b_pkt_lkp_en,
  output logic [info_length-1:0]  c2b_pkt_lkp_info,
  output logic [order_id-1:0]     c2b_pkt_odr_id,
  output logic                    c2b_pkt_so,
  output logic [data_length-1:0]  c2b_pkt_payload,
  input  logic                    b2c_pkt_rdy,
  output logic [31:0]             tx_cnt
);

  logic [1:0]              cnt;
  logic [1:0]              ptr;
  logic [buffer_width-1:0] head;
  logic [buffer_width-1:0] second;
  logic [31:0]             tx_cnt_r;

  logic                    acc;
  logic                    push;
  logic                    pop;
  logic [2:0]              req;
  logic [2:0]              gnt;
  logic [buffer_width-1:0] push_data;

  // Accept depends only on registered occupancy, so pops never wait on B combinationally.
  assign acc = !rst && (cnt < 2'd2);
  assign req = {~src3_empty, ~src2_empty, ~src1_empty};

  always_comb begin
    gnt = 3'b000;
    if (acc) begin
      case (ptr)
        2'd1: begin
          if (req[0])      gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
        end
        2'd2: begin
          if (req[1])      gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
        end
        default: begin
          if (req[2])      gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
        end
      endcase
    end
  end

  always_comb begin
    push_data = '0;
    if (gnt[0])      push_data = src1_data;
    else if (gnt[1]) push_data = src2_data;
    else if (gnt[2]) push_data = src3_data;
  end

  assign push    = |gnt;
  assign pop     = (cnt != 2'd0) && b2c_pkt_rdy;
  assign src1_rd = gnt[0];
  assign src2_rd = gnt[1];
  assign src3_rd = gnt[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 2'd1;
    end else if (gnt[0]) begin
      ptr <= 2'd2;
    end else if (gnt[1]) begin
      ptr <= 2'd3;
    end else if (gnt[2]) begin
      ptr <= 2'd1;
    end
  end

  // Simultaneous push/pop only occurs at cnt==1 (acc blocks push at cnt==2), so new data lands in head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 2'd0;
      head   <= '0;
      second <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= push_data;
          else             second <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= second;
          cnt  <= cnt - 2'd1;
        end
        2'b11: head <= push_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      tx_cnt_r <= 32'd0;
    else if (pop) tx_cnt_r <= tx_cnt_r + 32'd1;
  end

  assign tx_cnt      = tx_cnt_r;
  assign c2b_pkt_vld = (cnt != 2'd0);
  assign {c2b_pkt_lkp_en, c2b_pkt_lkp_info, c2b_pkt_odr_id, c2b_pkt_so, c2b_pkt_payload} = head;

  a_no_empty_pop: assert property (@(posedge clk) disable iff (rst)
    !((src1_rd && src1_empty) || (src2_rd && src2_empty) || (src3_rd && src3_empty)));
  a_single_pop: assert property (@(posedge clk) disable iff (rst)
    $onehot0({src3_rd, src2_rd, src1_rd}));

endmodule

// File: tb/tb_output_interface.sv
// Directed bench for output_interface: FWFT queue models feed the DUT, a scoreboard checks delivery order and contents.
module tb_output_interface;
  localparam int IL = 20;
  localparam int OL = 3;
  localparam int DL = 512;
  localparam int BW = 1 + IL + OL + 1 + DL;
  typedef logic [BW-1:0] rec_t;

  logic          clk = 1'b0;
  logic          rst;
  rec_t          src1_data, src2_data, src3_data;
  logic          src1_empty, src2_empty, src3_empty;
  logic          src1_rd, src2_rd, src3_rd;
  logic          c2b_pkt_vld;
  logic          c2b_pkt_lkp_en;
  logic [IL-1:0] c2b_pkt_lkp_info;
  logic [OL-1:0] c2b_pkt_odr_id;
  logic          c2b_pkt_so;
  logic [DL-1:0] c2b_pkt_payload;
  logic          b2c_pkt_rdy;
  logic [31:0]   tx_cnt;
  rec_t          out_rec;

  output_interface #(.info_length(IL), .order_id(OL), .data_length(DL)) dut (
    .clk(clk), .rst(rst),
    .src1_data(src1_data), .src2_data(src2_data), .src3_data(src3_data),
    .src1_empty(src1_empty), .src2_empty(src2_empty), .src3_empty(src3_empty),
    .src1_rd(src1_rd), .src2_rd(src2_rd), .src3_rd(src3_rd),
    .c2b_pkt_vld(c2b_pkt_vld), .c2b_pkt_lkp_en(c2b_pkt_lkp_en),
    .c2b_pkt_lkp_info(c2b_pkt_lkp_info), .c2b_pkt_odr_id(c2b_pkt_odr_id),
    .c2b_pkt_so(c2b_pkt_so), .c2b_pkt_payload(c2b_pkt_payload),
    .b2c_pkt_rdy(b2c_pkt_rdy), .tx_cnt(tx_cnt)
  );

  always #5 clk = ~clk;

  assign out_rec = {c2b_pkt_lkp_en, c2b_pkt_lkp_info, c2b_pkt_odr_id, c2b_pkt_so, c2b_pkt_payload};

  rec_t sq1[$], sq2[$], sq3[$], exp_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic rec_t mk(input logic le, input logic [IL-1:0] info, input logic [OL-1:0] odr,
                              input logic so, input logic [31:0] tag);
    mk = {le, info, odr, so, {16{tag}}};
  endfunction

  task automatic upd_src();
    src1_data  = (sq1.size() > 0) ? sq1[0] : '0;
    src2_data  = (sq2.size() > 0) ? sq2[0] : '0;
    src3_data  = (sq3.size() > 0) ? sq3[0] : '0;
    src1_empty = (sq1.size() == 0);
    src2_empty = (sq2.size() == 0);
    src3_empty = (sq3.size() == 0);
  endtask

  task automatic chk(input string tag, input rec_t obs, input rec_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue model and scoreboard: sample mid-cycle, apply pops and compare transfers just after the edge.
  logic [2:0] m_rd;
  logic       m_x;
  rec_t       m_rec;
  always begin
    @(negedge clk); #1;
    m_rd  = {src3_rd, src2_rd, src1_rd};
    m_x   = c2b_pkt_vld && b2c_pkt_rdy && !rst;
    m_rec = out_rec;
    @(posedge clk); #1;
    if (m_rd[0]) begin
      chk("pop_src1_nonempty", rec_t'(sq1.size() > 0), rec_t'(1));
      if (sq1.size() > 0) void'(sq1.pop_front());
    end
    if (m_rd[1]) begin
      chk("pop_src2_nonempty", rec_t'(sq2.size() > 0), rec_t'(1));
      if (sq2.size() > 0) void'(sq2.pop_front());
    end
    if (m_rd[2]) begin
      chk("pop_src3_nonempty", rec_t'(sq3.size() > 0), rec_t'(1));
      if (sq3.size() > 0) void'(sq3.pop_front());
    end
    upd_src();
    if (m_x) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer", m_rec, '1);
      end else begin
        chk("xfer_data", m_rec, exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sq1.delete(); sq2.delete(); sq3.delete(); exp_q.delete();
    upd_src();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || c2b_pkt_vld) && n < max_cyc) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, rec_t'(exp_q.size() == 0 && !c2b_pkt_vld), rec_t'(1));
  endtask

  initial begin
    rec_t p;
    rec_t pk[5];
    rec_t prev_rec;
    logic prev_stall;
    bit   drained;

    rst = 1'b1;
    b2c_pkt_rdy = 1'b0;
    upd_src();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_vld", rec_t'(c2b_pkt_vld), '0);
    chk("rst_rec", out_rec, '0);
    chk("rst_tx_cnt", rec_t'(tx_cnt), '0);
    chk("rst_rd", rec_t'({src3_rd, src2_rd, src1_rd}), '0);
    @(negedge clk);
    rst = 1'b0;

    // Single packet on src1
    @(negedge clk);
    b2c_pkt_rdy = 1'b1;
    p = {1'b0, 20'h12345, 3'd0, 1'b1, {64{8'hA5}}};
    sq1.push_back(p); exp_q.push_back(p); upd_src();
    #1;
    chk("single_rd_pulse", rec_t'({src3_rd, src2_rd, src1_rd}), rec_t'(3'b001));
    chk("single_vld_before", rec_t'(c2b_pkt_vld), '0);
    @(negedge clk); #1;
    chk("single_rd_done", rec_t'({src3_rd, src2_rd, src1_rd}), '0);
    chk("single_vld", rec_t'(c2b_pkt_vld), rec_t'(1));
    chk("single_rec", out_rec, p);
    @(negedge clk); #1;
    chk("single_tx_cnt", rec_t'(tx_cnt), rec_t'(1));
    chk("single_vld_after", rec_t'(c2b_pkt_vld), '0);

    // Round-robin fairness: 4 packets on each source
    do_reset();
    b2c_pkt_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sq1.push_back(mk(1'b0, 20'h10000 + IL'(k), 3'd0, 1'b1, 32'h1000_0000 + k));
      sq2.push_back(mk(1'b1, 20'h20000 + IL'(k), 3'd0, 1'b0, 32'h2000_0000 + k));
      sq3.push_back(mk(1'b1, 20'h30000 + IL'(k), 3'(k + 1), 1'b1, 32'h3000_0000 + k));
    end
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(mk(1'b0, 20'h10000 + IL'(k), 3'd0, 1'b1, 32'h1000_0000 + k));
      exp_q.push_back(mk(1'b1, 20'h20000 + IL'(k), 3'd0, 1'b0, 32'h2000_0000 + k));
      exp_q.push_back(mk(1'b1, 20'h30000 + IL'(k), 3'(k + 1), 1'b1, 32'h3000_0000 + k));
    end
    upd_src();
    repeat (12) @(negedge clk);
    #1;
    chk("rr_tx_cnt_11", rec_t'(tx_cnt), rec_t'(11));
    @(negedge clk); #1;
    chk("rr_tx_cnt_12", rec_t'(tx_cnt), rec_t'(12));
    chk("rr_drained", rec_t'(exp_q.size()), '0);

    // Backpressure: B stalled, src3 holds 5 packets
    do_reset();
    b2c_pkt_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pk[k] = mk(k[0], 20'hB0000 + IL'(k), 3'(k + 2), ~k[0], 32'hB00B_0000 + k);
      sq3.push_back(pk[k]); exp_q.push_back(pk[k]);
    end
    upd_src();
    repeat (5) begin
      @(negedge clk); #1;
      chk("bp_vld", rec_t'(c2b_pkt_vld), rec_t'(1));
      chk("bp_stable", out_rec, pk[0]);
    end
    chk("bp_two_pops", rec_t'(sq3.size()), rec_t'(3));
    chk("bp_no_rd", rec_t'(src3_rd), '0);
    @(negedge clk);
    b2c_pkt_rdy = 1'b1;
    wait_drain("bp_drain", 20);
    chk("bp_tx_cnt", rec_t'(tx_cnt), rec_t'(5));

    // Alternating ready with two sources: grant order alternates 1,2
    do_reset();
    for (int k = 0; k < 3; k++) begin
      sq1.push_back(mk(1'b1, 20'hA0000 + IL'(k), 3'd0, 1'b0, 32'hA1A1_0000 + k));
      sq2.push_back(mk(1'b0, 20'hC0000 + IL'(k), 3'd0, 1'b1, 32'hC2C2_0000 + k));
      exp_q.push_back(mk(1'b1, 20'hA0000 + IL'(k), 3'd0, 1'b0, 32'hA1A1_0000 + k));
      exp_q.push_back(mk(1'b0, 20'hC0000 + IL'(k), 3'd0, 1'b1, 32'hC2C2_0000 + k));
    end
    upd_src();
    prev_stall = 1'b0;
    prev_rec = '0;
    drained = 1'b0;
    for (int i = 0; i < 30 && !drained; i++) begin
      @(negedge clk);
      b2c_pkt_rdy = ~i[0];
      #1;
      if (prev_stall) chk("alt_stall_hold", out_rec, prev_rec);
      prev_stall = c2b_pkt_vld && !b2c_pkt_rdy;
      prev_rec = out_rec;
      drained = (exp_q.size() == 0) && !c2b_pkt_vld;
    end
    chk("alt_drained", rec_t'(drained), rec_t'(1));
    chk("alt_tx_cnt", rec_t'(tx_cnt), rec_t'(6));

    // Async reset with a full buffer
    do_reset();
    b2c_pkt_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sq1.push_back(mk(1'b0, IL'(k + 1), 3'd0, 1'b0, 32'hD100_0000 + k));
      sq2.push_back(mk(1'b1, IL'(k + 2), 3'd0, 1'b0, 32'hD200_0000 + k));
      sq3.push_back(mk(1'b1, IL'(k + 3), 3'd5, 1'b0, 32'hD300_0000 + k));
      exp_q.push_back(mk(1'b0, IL'(k + 1), 3'd0, 1'b0, 32'hD100_0000 + k));
      exp_q.push_back(mk(1'b1, IL'(k + 2), 3'd0, 1'b0, 32'hD200_0000 + k));
      exp_q.push_back(mk(1'b1, IL'(k + 3), 3'd5, 1'b0, 32'hD300_0000 + k));
    end
    upd_src();
    repeat (3) @(negedge clk);
    b2c_pkt_rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_tx_cnt", rec_t'(tx_cnt), rec_t'(2));
    chk("mid_vld", rec_t'(c2b_pkt_vld), rec_t'(1));
    @(negedge clk);
    rst = 1'b1;
    sq1.delete(); sq2.delete(); sq3.delete(); exp_q.delete();
    upd_src();
    #1;
    chk("arst_vld", rec_t'(c2b_pkt_vld), '0);
    chk("arst_tx_cnt", rec_t'(tx_cnt), '0);
    chk("arst_rec", out_rec, '0);
    @(negedge clk);
    rst = 1'b0;
    b2c_pkt_rdy = 1'b1;
    sq1.push_back(mk(1'b0, 20'hE1, 3'd0, 1'b1, 32'hE1E1_E1E1));
    sq2.push_back(mk(1'b1, 20'hE2, 3'd0, 1'b1, 32'hE2E2_E2E2));
    sq3.push_back(mk(1'b1, 20'hE3, 3'd7, 1'b1, 32'hE3E3_E3E3));
    exp_q.push_back(mk(1'b0, 20'hE1, 3'd0, 1'b1, 32'hE1E1_E1E1));
    exp_q.push_back(mk(1'b1, 20'hE2, 3'd0, 1'b1, 32'hE2E2_E2E2));
    exp_q.push_back(mk(1'b1, 20'hE3, 3'd7, 1'b1, 32'hE3E3_E3E3));
    upd_src();
    #1;
    chk("post_rst_grant", rec_t'({src3_rd, src2_rd, src1_rd}), rec_t'(3'b001));
    wait_drain("post_rst_drain", 20);
    chk("post_rst_tx_cnt", rec_t'(tx_cnt), rec_t'(3));

    // Counter wrap
    @(negedge clk);
    force dut.tx_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.tx_cnt_r;
    #1;
    chk("wrap_preset", rec_t'(tx_cnt), rec_t'(32'hFFFF_FFFF));
    @(negedge clk);
    p = mk(1'b1, 20'hFFFFF, 3'd3, 1'b0, 32'h5A5A_C3C3);
    sq1.push_back(p); exp_q.push_back(p); upd_src();
    repeat (2) @(negedge clk);
    #1;
    chk("wrap_tx_cnt", rec_t'(tx_cnt), '0);
    chk("wrap_drained", rec_t'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
